// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings and FSM states.
// MULDIV_SIGNED_EN (when defined) enables signed ops and the FIX state in the sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULU = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the execute stage (master) and the sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             divByZero;

  modport master (
    output start, op, x, y,
    input  busy, done, lo, hi, divByZero
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, lo, hi, divByZero
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration on the {hi,lo} accumulator: shift-add for multiply,
// restoring trial-subtract-shift for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      // Borrow out of the top bit means the trial subtract failed: restore.
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer, one accumulator bit per cycle.
// Define MULDIV_SIGNED_EN to enable signed MUL/DIV with a sign-fix state.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// RUN    | WIDTH iterations of muldiv_step
// FIX    | sign correction of the magnitude result (MULDIV_SIGNED_EN only)
// DONE   | results valid, done pulse, back to IDLE
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] res_acc;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   xorig_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               is_div_q;
  logic               dbz_q;
  logic               dbz_out_q;
  logic               accept;
  logic               acc_is_div;
  logic [WIDTH-1:0]   mag_x;
  logic [WIDTH-1:0]   mag_y;

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign acc_is_div = (bus.op == OP_DIVU) || (bus.op == OP_DIV);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .is_div_i(is_div_q),
    .acc_o   (step_acc)
  );

`ifdef MULDIV_SIGNED_EN
  logic               acc_signed;
  logic               neg_x;
  logic               neg_y;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic [2*WIDTH-1:0] fix_acc;

  assign acc_signed = (bus.op == OP_MUL) || (bus.op == OP_DIV);
  assign neg_x      = acc_signed & bus.x[WIDTH-1];
  assign neg_y      = acc_signed & bus.y[WIDTH-1];
  assign mag_x      = neg_x ? -bus.x : bus.x;
  assign mag_y      = neg_y ? -bus.y : bus.y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      neg_lo_q <= neg_x ^ neg_y;
      neg_hi_q <= neg_x;
    end
  end

  // Quotient sign follows x^y, remainder follows x; a product negates as a whole.
  always_comb begin
    fix_acc = acc_q;
    if (!is_div_q) begin
      if (neg_lo_q) fix_acc = -acc_q;
    end else begin
      if (neg_lo_q) fix_acc[WIDTH-1:0]       = -acc_q[WIDTH-1:0];
      if (neg_hi_q) fix_acc[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
    end
  end

  assign res_acc = (state_q == S_FIX) ? fix_acc : step_acc;
`else
  assign mag_x   = bus.x;
  assign mag_y   = bus.y;
  assign res_acc = step_acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (cnt_q == LAST) begin
`ifdef MULDIV_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      xorig_q   <= '0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        is_div_q <= acc_is_div;
        dbz_q    <= acc_is_div && (bus.y == '0);
        xorig_q  <= bus.x;
        opnd_q   <= acc_is_div ? mag_y : mag_x;
        acc_q    <= {{WIDTH{1'b0}}, (acc_is_div ? mag_x : mag_y)};
      end else if (state_q == S_RUN) begin
        acc_q <= step_acc;
        cnt_q <= cnt_q + CW'(1);
      end
      // Results register on the way into DONE and hold until the next op finishes.
      if (state_d == S_DONE) begin
        lo_q      <= dbz_q ? '1 : res_acc[WIDTH-1:0];
        hi_q      <= dbz_q ? xorig_q : res_acc[2*WIDTH-1:WIDTH];
        dbz_out_q <= dbz_q;
      end
    end
  end

  assign bus.lo        = lo_q;
  assign bus.hi        = hi_q;
  assign bus.divByZero = dbz_out_q;

endmodule
